// File: rtl/count_readout_ctrl.sv
// count_readout_ctrl: walks the pop-counter select line, captures each count into a
// shadow copy and publishes all counts plus their sum as one atomic snapshot.
// A readout stops early on a missing valid (timeout) or on loss of idle (abort).
module count_readout_ctrl #(
    parameter int NUM_CNT = 5,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               idle,
    input  logic                               req,
    input  logic                               valid,
    input  logic [CNT_W-1:0]                   data_out,
    output logic [IDX_W-1:0]                   idx,
    output logic                               busy,
    output logic [NUM_CNT*CNT_W-1:0]           cnt_bus,
    output logic [CNT_W+$clog2(NUM_CNT)-1:0]   total,
    output logic                               done,
    output logic                               err_timeout,
    output logic                               err_abort
);

    localparam int TOT_W = CNT_W + $clog2(NUM_CNT);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT
    } state_t;

    state_t                     state;
    logic [NUM_CNT*CNT_W-1:0]   shadow;
    logic [NUM_CNT*CNT_W-1:0]   shadow_next;
    logic [TOT_W-1:0]           sum;
    logic [TOT_W-1:0]           sum_next;
    logic [TMR_W-1:0]           timer;

    // Shadow copy and running sum as they would look if the current data_out is captured.
    always_comb begin
        shadow_next = shadow;
        sum_next    = sum + TOT_W'(data_out);
        for (int k = 0; k < NUM_CNT; k++) begin
            if (idx == IDX_W'(k)) begin
                shadow_next[k*CNT_W +: CNT_W] = data_out;
            end
        end
    end

    // Readout sequencer: select settle, capture or time out, publish snapshot on the last capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            cnt_bus     <= '0;
            total       <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
            shadow      <= '0;
            sum         <= '0;
            timer       <= '0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
            case (state)
                IDLE: begin
                    idx  <= '0;
                    busy <= 1'b0;
                    if (req && idle) begin
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!idle) begin
                        err_abort <= 1'b1;
                        idx       <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!idle) begin
                        err_abort <= 1'b1;
                        idx       <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (valid) begin
                        shadow <= shadow_next;
                        sum    <= sum_next;
                        if (idx == LAST_IDX) begin
                            cnt_bus <= shadow_next;
                            total   <= sum_next;
                            done    <= 1'b1;
                            idx     <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SETTLE;
                        end
                    end else if (timer == TMR_LAST) begin
                        err_timeout <= 1'b1;
                        idx         <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
